fetch_s_tx: RTL and testbench
=============================

FETCH_S_TX -- requirements
Module: fetch_s_tx

Interface
REQ-001 Parameter BIT_CLKS, default 8: clk_sys cycles per serial bit (range 2..255).
REQ-002 Parameter SLOT_US, default 100: response slot width in microseconds per dev_id step.
REQ-003 Parameter WORDS, default 4: data words per frame (range 1..255).
REQ-004 clk_sys  in  1  system clock; the block has one clock; all logic is on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 pluse_us  in  1  one-cycle strobe, once per microsecond.
REQ-007 fire_sync  in  1  one-cycle sync pulse; starts one response frame.
REQ-008 dev_id  in  4  slave address; sets slot delay and frame header; static during a frame.
REQ-009 dat  in  16  upstream data word.
REQ-010 dat_vld  in  1  dat holds a valid word.
REQ-011 dat_rdy  out  1  one-cycle accept strobe; a word transfers when dat_rdy=1 and dat_vld=1.
REQ-012 tx_ctrl  out  1  RS485 driver enable.
REQ-013 tx_a  out  1  serial data line; idle value 1.
REQ-014 tx_b  out  1  frame marker; 1 only while header, data or checksum bits are driven.
REQ-015 busy  out  1  1 whenever the state is not IDLE.
REQ-016 err_udf  out  1  sticky underflow flag.

Function
REQ-017 States SHALL be IDLE, WAIT, PRE, WORD and POST; all outputs are registered.
REQ-018 Transition IDLE->WAIT SHALL occur on fire_sync=1; the strobe counter clears and err_udf clears on the same edge.
REQ-019 In WAIT, the block SHALL count pluse_us strobes and move to PRE when count == dev_id*SLOT_US; with dev_id=0 it moves to PRE on the cycle after entering WAIT.
REQ-020 In PRE, outputs SHALL be tx_ctrl=1, tx_a=1 and tx_b=0 for 2*BIT_CLKS cycles.
REQ-021 WORD SHALL send WORDS+2 words in order: header {4'hA, dev_id, WORDS[7:0]}, then WORDS data words, then the checksum.
REQ-022 Each word SHALL be 18 bits: start bit 0, 16 data bits LSB first, stop bit 1; each bit is held for exactly BIT_CLKS cycles.
REQ-023 Data-word load: on the last cycle of the preceding word's stop bit, the block SHALL drive dat_rdy=1 for one cycle and capture dat when dat_vld=1.
REQ-024 If dat_vld=0 at the load cycle, the block SHALL send 16'h0000 for that word and set err_udf=1; dat_rdy is still pulsed and the frame continues.
REQ-025 Checksum SHALL be the mod-2^16 sum of the header and all sent data words (substituted zeros included).
REQ-026 POST SHALL hold tx_ctrl=1 and tx_a=1 for BIT_CLKS cycles, then move to IDLE with tx_ctrl=0.
REQ-027 Total tx_ctrl-high time SHALL be (2 + 18*(WORDS+2) + 1)*BIT_CLKS cycles.
REQ-028 A fire_sync that arrives while busy=1 SHALL be ignored, with no restart and no effect on err_udf.
REQ-029 A fire_sync on the same cycle that POST exits SHALL be ignored; fire_sync is accepted only in IDLE.
REQ-030 Changing dev_id mid-frame is not supported; header and delay use the value sampled on entry to WAIT.
REQ-031 The bit counter and word counter SHALL wrap cleanly: no extra or missing bit cycles between words.

Reset
REQ-032 When rst_n=0 at a clock edge, the next state SHALL be IDLE with tx_ctrl=0, tx_a=1, tx_b=0, dat_rdy=0, busy=0, err_udf=0 and all counters cleared.
REQ-033 Reset asserted mid-frame SHALL abort the frame; tx_ctrl drops on that edge, and no partial word is resumed after reset is released.

Verification
REQ-034 BIT_CLKS=8, WORDS=4, dev_id=0, dat_vld=1 with words 0x1234, 0x5678, 0x9ABC, 0xDEF0, then fire_sync -> header 0xA004, four data words, checksum 0x825C, tx_ctrl high for exactly 888 cycles, four dat_rdy pulses, err_udf=0.
REQ-035 dev_id=3, SLOT_US=100, then fire_sync -> tx_ctrl rises after 300 pluse_us strobes and the header reads 0xA304.
REQ-036 dat_vld=0 for the third word -> that word is sent as 0x0000, the checksum excludes the missing value, and err_udf=1 until the next accepted fire_sync.
REQ-037 Second fire_sync 200 cycles into a frame -> frame unchanged and exactly one frame sent.
REQ-038 rst_n=0 for one cycle during data word 2 -> tx_ctrl=0, tx_a=1, busy=0 on the next edge, and no further dat_rdy until a new fire_sync.
REQ-039 Bit-timing check with BIT_CLKS=2 -> every bit is exactly 2 cycles wide, the start bit is 0, the stop bit is 1, and there are no gaps between words.

Source files
------------

// File: rtl/fetch_s_tx.sv
// fetch_s_tx: slotted RS485 response transmitter.
// After a fire_sync, the block waits dev_id*SLOT_US microsecond strobes.
// It then drives a preamble and WORDS+2 serial words (header, data, checksum).
// It ends with a one-bit postamble.
// Each word goes out as a start bit (0), 16 data bits LSB first, and a stop bit (1).
//
// Ports:
//   clk_sys   in   system clock (rising edge)
//   rst_n     in   synchronous active-low reset
//   pluse_us  in   one-cycle strobe per microsecond
//   fire_sync in   starts one response frame (accepted only while idle)
//   dev_id    in   [3:0] slave address (slot delay and header)
//   dat       in   [15:0] upstream data word
//   dat_vld   in   dat holds a valid word
//   dat_rdy   out  one-cycle accept strobe for dat
//   tx_ctrl   out  RS485 driver enable
//   tx_a      out  serial data line (idles at 1)
//   tx_b      out  frame marker, high while header/data/checksum bits are driven
//   busy      out  high whenever the FSM is not idle
//   err_udf   out  sticky underflow flag (data word missing at load time)
module fetch_s_tx #(
    parameter int BIT_CLKS = 8,
    parameter int SLOT_US  = 100,
    parameter int WORDS    = 4
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        pluse_us,
    input  logic        fire_sync,
    input  logic [3:0]  dev_id,
    input  logic [15:0] dat,
    input  logic        dat_vld,
    output logic        dat_rdy,
    output logic        tx_ctrl,
    output logic        tx_a,
    output logic        tx_b,
    output logic        busy,
    output logic        err_udf
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_PRE  = 3'd2,
        ST_WORD = 3'd3,
        ST_POST = 3'd4
    } state_t;

    localparam logic [8:0]  BIT_LAST   = 9'(BIT_CLKS - 1);
    localparam logic [8:0]  PRE_LAST   = 9'(2 * BIT_CLKS - 1);
    localparam logic [8:0]  DATA_WORDS = 9'(WORDS);
    localparam logic [8:0]  LAST_WORD  = 9'(WORDS + 1);
    localparam logic [7:0]  WORDS_B    = 8'(WORDS);
    localparam logic [31:0] SLOT_W     = 32'(SLOT_US);
    localparam logic [4:0]  STOP_BIT   = 5'd17;

    // Checksum accumulation, wrapping modulo 2^16.
    function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] val);
        csum_add = acc + val;
    endfunction

    state_t       state_r, state_s;
    logic [31:0]  us_cnt_r, us_cnt_s;
    logic [8:0]   clk_cnt_r, clk_cnt_s;
    logic [4:0]   bit_cnt_r, bit_cnt_s;
    logic [8:0]   word_cnt_r, word_cnt_s;
    logic [15:0]  word_r, word_s;
    logic [15:0]  csum_r, csum_s;
    logic [3:0]   id_r, id_s;
    logic         err_s;
    logic         rdy_s, ctrl_s, a_s, b_s, busy_s;
    logic [3:0]   didx_s;
    logic [31:0]  target_s;
    logic [15:0]  load_s;
    logic [15:0]  header_s;

    // Next-state, counter and next-output computation.
    always_comb begin
        state_s    = state_r;
        us_cnt_s   = us_cnt_r;
        clk_cnt_s  = clk_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        word_cnt_s = word_cnt_r;
        word_s     = word_r;
        csum_s     = csum_r;
        id_s       = id_r;
        err_s      = err_udf;
        target_s   = {28'd0, id_r} * SLOT_W;
        header_s   = {4'hA, id_r, WORDS_B};
        // A missing word is replaced by zero; that zero also enters the checksum.
        load_s     = dat_vld ? dat : 16'h0000;

        case (state_r)
            ST_IDLE: begin
                if (fire_sync) begin
                    state_s  = ST_WAIT;
                    us_cnt_s = 32'd0;
                    err_s    = 1'b0;
                    id_s     = dev_id;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (us_cnt_r == target_s) begin
                    state_s   = ST_PRE;
                    clk_cnt_s = 9'd0;
                end else if (pluse_us) begin
                    us_cnt_s = us_cnt_r + 32'd1;
                end else begin
                    us_cnt_s = us_cnt_r;
                end
            end
            ST_PRE: begin
                if (clk_cnt_r == PRE_LAST) begin
                    state_s    = ST_WORD;
                    clk_cnt_s  = 9'd0;
                    bit_cnt_s  = 5'd0;
                    word_cnt_s = 9'd0;
                    word_s     = header_s;
                    csum_s     = header_s;
                end else begin
                    clk_cnt_s = clk_cnt_r + 9'd1;
                end
            end
            ST_WORD: begin
                if (clk_cnt_r != BIT_LAST) begin
                    clk_cnt_s = clk_cnt_r + 9'd1;
                end else begin
                    clk_cnt_s = 9'd0;
                    if (bit_cnt_r != STOP_BIT) begin
                        bit_cnt_s = bit_cnt_r + 5'd1;
                    end else if (word_cnt_r == LAST_WORD) begin
                        state_s = ST_POST;
                    end else begin
                        // End of a stop bit: the next word starts with no gap.
                        bit_cnt_s  = 5'd0;
                        word_cnt_s = word_cnt_r + 9'd1;
                        if (word_cnt_r < DATA_WORDS) begin
                            word_s = load_s;
                            csum_s = csum_add(csum_r, load_s);
                            err_s  = err_udf | ~dat_vld;
                        end else begin
                            word_s = csum_r;
                        end
                    end
                end
            end
            ST_POST: begin
                if (clk_cnt_r == BIT_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    clk_cnt_s = clk_cnt_r + 9'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Outputs are derived from next-state values so they register in step with the state.
        didx_s = bit_cnt_s[3:0] - 4'd1;
        ctrl_s = (state_s == ST_PRE) || (state_s == ST_WORD) || (state_s == ST_POST);
        b_s    = (state_s == ST_WORD);
        busy_s = (state_s != ST_IDLE);
        if (state_s == ST_WORD) begin
            if (bit_cnt_s == 5'd0) begin
                a_s = 1'b0;
            end else if (bit_cnt_s == STOP_BIT) begin
                a_s = 1'b1;
            end else begin
                a_s = word_s[didx_s];
            end
        end else begin
            a_s = 1'b1;
        end
        // dat_rdy is high during the last cycle of the stop bit that precedes a data word.
        rdy_s = (state_s == ST_WORD) && (bit_cnt_s == STOP_BIT) &&
                (clk_cnt_s == BIT_LAST) && (word_cnt_s < DATA_WORDS);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            us_cnt_r   <= 32'd0;
            clk_cnt_r  <= 9'd0;
            bit_cnt_r  <= 5'd0;
            word_cnt_r <= 9'd0;
            word_r     <= 16'h0000;
            csum_r     <= 16'h0000;
            id_r       <= 4'd0;
            err_udf    <= 1'b0;
            dat_rdy    <= 1'b0;
            tx_ctrl    <= 1'b0;
            tx_a       <= 1'b1;
            tx_b       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_s;
            us_cnt_r   <= us_cnt_s;
            clk_cnt_r  <= clk_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            word_cnt_r <= word_cnt_s;
            word_r     <= word_s;
            csum_r     <= csum_s;
            id_r       <= id_s;
            err_udf    <= err_s;
            dat_rdy    <= rdy_s;
            tx_ctrl    <= ctrl_s;
            tx_a       <= a_s;
            tx_b       <= b_s;
            busy       <= busy_s;
        end
    end

endmodule

// File: tb/tb_fetch_s_tx.sv
// Directed testbench for fetch_s_tx.
// Two instances are used: one with BIT_CLKS=8 and one with BIT_CLKS=2.
// The bench decodes each serial frame cycle by cycle against a hand-computed schedule.
`timescale 1ns/1ps
module tb_fetch_s_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pluse_us;
    logic        fire8, fire2;
    logic [3:0]  dev_id;
    logic [15:0] dat;
    logic        dat_vld;
    logic        rdy8, ctrl8, a8, b8, busy8, err8;
    logic        rdy2, ctrl2, a2, b2, busy2, err2;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] dtbl [0:7];
    logic        vtbl [0:7];
    int          fi;
    logic        prev_rdy;
    int          sel;
    logic        c_ctrl, c_a, c_b, c_rdy, c_busy;
    logic [15:0] rx_w [0:5];
    int          shape_err;
    int          rdy_cnt;
    int          hi8 = 0;
    int          hi2 = 0;
    int          strobes = 0;

    // 100 MHz system clock.
    always #5 clk = ~clk;

    fetch_s_tx #(.BIT_CLKS(8), .SLOT_US(100), .WORDS(4)) u_dut8 (
        .clk_sys(clk), .rst_n(rst_n), .pluse_us(pluse_us), .fire_sync(fire8),
        .dev_id(dev_id), .dat(dat), .dat_vld(dat_vld), .dat_rdy(rdy8),
        .tx_ctrl(ctrl8), .tx_a(a8), .tx_b(b8), .busy(busy8), .err_udf(err8)
    );

    fetch_s_tx #(.BIT_CLKS(2), .SLOT_US(100), .WORDS(4)) u_dut2 (
        .clk_sys(clk), .rst_n(rst_n), .pluse_us(pluse_us), .fire_sync(fire2),
        .dev_id(dev_id), .dat(dat), .dat_vld(dat_vld), .dat_rdy(rdy2),
        .tx_ctrl(ctrl2), .tx_a(a2), .tx_b(b2), .busy(busy2), .err_udf(err2)
    );

    // Microsecond strobe: one cycle in four, changed just after the rising edge.
    initial begin
        int pdiv;
        pdiv = 0;
        pluse_us = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pdiv = pdiv + 1;
            pluse_us = ((pdiv % 4) == 0);
        end
    end

    // Driver-enable high-time counters and the strobe counter for the WAIT phase.
    always @(negedge clk) begin
        if (ctrl8) hi8 <= hi8 + 1;
        if (ctrl2) hi2 <= hi2 + 1;
        if (pluse_us && busy8 && !ctrl8) strobes <= strobes + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_fire(input logic v);
        if (sel == 0) fire8 = v;
        else fire2 = v;
    endtask

    // Advance one cycle to the falling edge, feed data after each accept, and sample the selected DUT.
    task automatic step();
        @(negedge clk);
        if (prev_rdy) begin
            if (fi < 7) fi++;
            dat = dtbl[fi];
            dat_vld = vtbl[fi];
        end
        if (sel == 0) begin
            c_ctrl = ctrl8; c_a = a8; c_b = b8; c_rdy = rdy8; c_busy = busy8;
        end else begin
            c_ctrl = ctrl2; c_a = a2; c_b = b2; c_rdy = rdy2; c_busy = busy2;
        end
        if (c_rdy) rdy_cnt++;
        prev_rdy = c_rdy;
    endtask

    task automatic start_frame();
        fi = 0;
        prev_rdy = 1'b0;
        dat = dtbl[0];
        dat_vld = vtbl[0];
        rdy_cnt = 0;
        set_fire(1'b1);
        step();
        set_fire(1'b0);
    endtask

    // Fire, then decode one frame against the expected cycle schedule.
    task automatic rx_frame(input int bc, input int refire_t);
        int   total, wt, w, bi, ci, budget;
        logic bitv, exp_rdy;
        shape_err = 0;
        for (int i = 0; i < 6; i++) rx_w[i] = 16'h0000;
        start_frame();
        budget = 0;
        while (!c_ctrl && budget < 5000) begin
            step();
            budget++;
        end
        if (!c_ctrl) begin
            chk("ctrl_rise_timeout", 32'd0, 32'd1);
            return;
        end
        total = 111 * bc;
        bitv = 1'b1;
        for (int t = 0; t <= total; t++) begin
            if (t > 0) step();
            set_fire(t == refire_t);
            exp_rdy = 1'b0;
            if (t < 2 * bc) begin
                if (c_ctrl !== 1'b1 || c_a !== 1'b1 || c_b !== 1'b0) shape_err++;
            end else if (t < 110 * bc) begin
                wt = t - 2 * bc;
                w  = wt / (18 * bc);
                bi = (wt % (18 * bc)) / bc;
                ci = wt % bc;
                if (c_ctrl !== 1'b1 || c_b !== 1'b1) shape_err++;
                if (ci == 0) begin
                    bitv = c_a;
                    if (bi >= 1 && bi <= 16) rx_w[w][bi-1] = c_a;
                end else if (c_a !== bitv) begin
                    shape_err++;
                end
                if (bi == 0 && c_a !== 1'b0) shape_err++;
                if (bi == 17 && c_a !== 1'b1) shape_err++;
                exp_rdy = (w < 4) && (bi == 17) && (ci == bc - 1);
            end else if (t < total) begin
                if (c_ctrl !== 1'b1 || c_a !== 1'b1 || c_b !== 1'b0) shape_err++;
            end else begin
                if (c_ctrl !== 1'b0 || c_a !== 1'b1 || c_b !== 1'b0 || c_busy !== 1'b0) shape_err++;
            end
            if (c_rdy !== exp_rdy) shape_err++;
        end
        set_fire(1'b0);
    endtask

    task automatic chk_words(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3,
                             input logic [15:0] w4, input logic [15:0] w5);
        chk({tag, "_hdr"},  {16'h0, rx_w[0]}, {16'h0, w0});
        chk({tag, "_d0"},   {16'h0, rx_w[1]}, {16'h0, w1});
        chk({tag, "_d1"},   {16'h0, rx_w[2]}, {16'h0, w2});
        chk({tag, "_d2"},   {16'h0, rx_w[3]}, {16'h0, w3});
        chk({tag, "_d3"},   {16'h0, rx_w[4]}, {16'h0, w4});
        chk({tag, "_csum"}, {16'h0, rx_w[5]}, {16'h0, w5});
        chk({tag, "_shape"}, 32'(shape_err), 32'd0);
    endtask

    // Watch the selected DUT while it should remain idle; returns the count of busy/enable cycles seen.
    task automatic idle_watch(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (c_busy || c_ctrl) seen++;
        end
    endtask

    initial begin
        int snap, seen;
        sel = 0;
        fire8 = 1'b0;
        fire2 = 1'b0;
        dev_id = 4'd0;
        dtbl[0] = 16'h1234; dtbl[1] = 16'h5678; dtbl[2] = 16'h9ABC; dtbl[3] = 16'hDEF0;
        dtbl[4] = 16'hFFFF; dtbl[5] = 16'hFFFF; dtbl[6] = 16'hFFFF; dtbl[7] = 16'hFFFF;
        for (int i = 0; i < 8; i++) vtbl[i] = 1'b1;
        fi = 0; prev_rdy = 1'b0; rdy_cnt = 0;
        dat = dtbl[0]; dat_vld = 1'b1;
        rst_n = 1'b0;
        step(); step(); step();
        chk("reset_outputs", {26'd0, ctrl8, a8, b8, rdy8, busy8, err8}, 32'b010000);
        rst_n = 1'b1;
        step();

        // Nominal frame, dev_id 0.
        snap = hi8;
        rx_frame(8, -1);
        chk_words("nom", 16'hA004, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h825C);
        chk("nom_ctrl_cycles", 32'(hi8 - snap), 32'd888);
        chk("nom_rdy_pulses", 32'(rdy_cnt), 32'd4);
        chk("nom_err", {31'd0, err8}, 32'd0);

        // Slot delay with dev_id 3.
        dev_id = 4'd3;
        snap = strobes;
        rx_frame(8, -1);
        chk("slot_strobes", 32'(strobes - snap), 32'd300);
        chk_words("id3", 16'hA304, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h855C);
        dev_id = 4'd0;

        // Third word missing; a fire during the last POST cycle is ignored.
        vtbl[2] = 1'b0;
        rx_frame(8, 887);
        chk_words("udf", 16'hA004, 16'h1234, 16'h5678, 16'h0000, 16'hDEF0, 16'hE7A0);
        chk("udf_rdy_pulses", 32'(rdy_cnt), 32'd4);
        chk("udf_err_set", {31'd0, err8}, 32'd1);
        idle_watch(30, seen);
        chk("post_exit_fire_ignored", 32'(seen), 32'd0);
        chk("udf_err_sticky", {31'd0, err8}, 32'd1);
        vtbl[2] = 1'b1;

        // Second fire 200 cycles into the frame is ignored; err clears on the accepted fire.
        snap = hi8;
        rx_frame(8, 200);
        chk_words("refire", 16'hA004, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h825C);
        chk("refire_err_cleared", {31'd0, err8}, 32'd0);
        idle_watch(100, seen);
        chk("refire_one_frame", 32'(seen), 32'd0);
        chk("refire_ctrl_cycles", 32'(hi8 - snap), 32'd888);

        // Reset during data word 2 aborts the frame.
        start_frame();
        seen = 0;
        while (!c_ctrl && seen < 100) begin
            step();
            seen++;
        end
        chk("abort_ctrl_rise", {31'd0, c_ctrl}, 32'd1);
        for (int i = 0; i < 330; i++) step();
        chk("abort_in_frame", {29'd0, c_ctrl, c_b, c_busy}, 32'b111);
        rst_n = 1'b0;
        step();
        chk("abort_reset_edge", {29'd0, c_ctrl, c_a, c_busy}, 32'b010);
        rst_n = 1'b1;
        rdy_cnt = 0;
        idle_watch(400, seen);
        chk("abort_quiet", 32'(seen + rdy_cnt), 32'd0);

        // Bit timing with BIT_CLKS=2.
        sel = 1;
        snap = hi2;
        rx_frame(2, -1);
        chk_words("bc2", 16'hA004, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h825C);
        chk("bc2_ctrl_cycles", 32'(hi2 - snap), 32'd222);
        chk("bc2_rdy_pulses", 32'(rdy_cnt), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
